// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction game core: FSM states, display
// width, default timeout and the LFSR feedback taps.
package reaction_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    MEASURE = 2'd2,
    RESULT  = 2'd3
  } state_e;

  localparam int DISP_W = 14;
  localparam int REACT_MAX_MS = 9999;

  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One Fibonacci step: shift left, feedback is the XOR of the tapped bits
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Brings a raw button pin into the clock domain and turns a press into a
// single-cycle event. A held button produces exactly one event.
module btn_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic evt_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Two-flop synchronizer followed by a delayed copy used for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign evt_o = sync_q & ~prev_q;

endmodule

// File: rtl/reaction_timer.sv
// Reaction game control core: random pre-go delay, millisecond reaction
// measurement with saturation/timeout and false-start detection.
// Optional macro REACTION_BEST_SCORE_EN adds a best_ms output that tracks
// the fastest valid reaction since reset.
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int          TICK_DIV     = 100000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          RAND_BITS    = 11,
  parameter int          MAX_MS       = REACT_MAX_MS,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_start,
  input  logic              btn_react,
  output logic [DISP_W-1:0] number,
  output logic              led_go,
  output logic              done,
  output logic              false_start
`ifdef REACTION_BEST_SCORE_EN
  ,
  output logic [DISP_W-1:0] best_ms
`endif
);

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DELAY_W = $clog2(MIN_DELAY_MS + 2 ** RAND_BITS);
  localparam logic [DISP_W-1:0] MS_MAX  = DISP_W'(MAX_MS);
  localparam logic [DISP_W-1:0] MS_LAST = DISP_W'(MAX_MS - 1);

  logic start_evt;
  logic react_evt;
  logic tick;

  state_e              state_q, state_d;
  logic [15:0]         lfsr_q;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [DELAY_W-1:0]  delay_q, delay_d;
  logic [DISP_W-1:0]   ms_q, ms_d;
  logic [DISP_W-1:0]   number_q, number_d;
  logic                led_go_q, led_go_d;
  logic                done_q, done_d;
  logic                false_q, false_d;
`ifdef REACTION_BEST_SCORE_EN
  logic [DISP_W-1:0]   best_q, best_d;
`endif

  btn_sync_edge u_start_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .btn_i  (btn_start),
    .evt_o  (start_evt)
  );

  btn_sync_edge u_react_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .btn_i  (btn_react),
    .evt_o  (react_evt)
  );

  assign tick = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

  // Next-state and output logic; prescaler restarts on WAIT/MEASURE entry
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    delay_d    = delay_q;
    ms_d       = ms_q;
    number_d   = number_q;
    led_go_d   = led_go_q;
    done_d     = done_q;
    false_d    = false_q;
`ifdef REACTION_BEST_SCORE_EN
    best_d     = best_q;
`endif
    case (state_q)
      IDLE, RESULT: begin
        if (start_evt) begin
          state_d    = WAIT;
          tick_cnt_d = '0;
          delay_d    = DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr_q[RAND_BITS-1:0]);
          ms_d       = '0;
          number_d   = '0;
          done_d     = 1'b0;
          false_d    = 1'b0;
        end
      end
      WAIT: begin
        if (react_evt) begin
          state_d  = RESULT;
          number_d = '0;
          false_d  = 1'b1;
          done_d   = 1'b1;
        end else if (tick) begin
          delay_d = delay_q - 1'b1;
          if (delay_q <= DELAY_W'(1)) begin
            state_d    = MEASURE;
            tick_cnt_d = '0;
            ms_d       = '0;
            led_go_d   = 1'b1;
          end
        end
      end
      MEASURE: begin
        if (react_evt) begin
          state_d  = RESULT;
          number_d = ms_q;
          led_go_d = 1'b0;
          done_d   = 1'b1;
`ifdef REACTION_BEST_SCORE_EN
          if (ms_q < best_q) best_d = ms_q;
`endif
        end else if (tick) begin
          if (ms_q >= MS_LAST) begin
            state_d  = RESULT;
            ms_d     = MS_MAX;
            number_d = MS_MAX;
            led_go_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            ms_d = ms_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and held outputs; the LFSR free-runs in every state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lfsr_q     <= LFSR_SEED;
      tick_cnt_q <= '0;
      delay_q    <= '0;
      ms_q       <= '0;
      number_q   <= '0;
      led_go_q   <= 1'b0;
      done_q     <= 1'b0;
      false_q    <= 1'b0;
`ifdef REACTION_BEST_SCORE_EN
      best_q     <= MS_MAX;
`endif
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_next(lfsr_q);
      tick_cnt_q <= tick_cnt_d;
      delay_q    <= delay_d;
      ms_q       <= ms_d;
      number_q   <= number_d;
      led_go_q   <= led_go_d;
      done_q     <= done_d;
      false_q    <= false_d;
`ifdef REACTION_BEST_SCORE_EN
      best_q     <= best_d;
`endif
    end
  end

  assign number      = number_q;
  assign led_go      = led_go_q;
  assign done        = done_q;
  assign false_start = false_q;
`ifdef REACTION_BEST_SCORE_EN
  assign best_ms     = best_q;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer: two instances share the buttons, one
// with the default timeout and one with MAX_MS=20 for the timeout round.
module tb_reaction_timer;

  logic        clk;
  logic        rst;
  logic        btn_start;
  logic        btn_react;
  logic [13:0] number, to_number;
  logic        led_go, to_led_go;
  logic        done, to_done;
  logic        false_start, to_false;
`ifdef REACTION_BEST_SCORE_EN
  logic [13:0] best_ms, to_best_ms;
`endif

  int tests = 0;
  int fails = 0;

  // Independent reference of the 16-bit LFSR (taps 16,14,13,11)
  logic [15:0] lfsr_m;

  reaction_timer #(
    .TICK_DIV(4), .MIN_DELAY_MS(5), .RAND_BITS(2), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_react(btn_react),
    .number(number), .led_go(led_go), .done(done), .false_start(false_start)
`ifdef REACTION_BEST_SCORE_EN
    , .best_ms(best_ms)
`endif
  );

  reaction_timer #(
    .TICK_DIV(4), .MIN_DELAY_MS(5), .RAND_BITS(2), .MAX_MS(20), .LFSR_SEED(16'hACE1)
  ) dut_to (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_react(btn_react),
    .number(to_number), .led_go(to_led_go), .done(to_done), .false_start(to_false)
`ifdef REACTION_BEST_SCORE_EN
    , .best_ms(to_best_ms)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) lfsr_m <= 16'hACE1;
    else      lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press start; returns the delay in ms the core must load; ends just after WAIT entry
  task automatic press_start(output int d);
    btn_start = 1'b0;
    step(3);
    btn_start = 1'b1;
    step(2);
    d = 5 + int'(lfsr_m[1:0]);
    step(1);
    btn_start = 1'b0;
  endtask

  task automatic wait_go(input bit use_to, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      cyc++;
      if ((use_to ? to_led_go : led_go) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called right after led_go is first seen; the event lands 4*ms+2 cycles after go
  task automatic react_at_ms(input int ms, input bit hold);
    step(4 * ms - 1);
    btn_react = 1'b1;
    step(3);
    if (!hold) btn_react = 1'b0;
  endtask

  task automatic test_reset();
    bit bad;
    rst = 1'b1; btn_start = 1'b0; btn_react = 1'b0;
    #2 rst = 1'b0;
    step(3);
    tests++; if (number !== 14'd0 || led_go !== 1'b0 || done !== 1'b0 || false_start !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_outputs: got num=%0d go=%b done=%b fs=%b, expected all 0", number, led_go, done, false_start); end
`ifdef REACTION_BEST_SCORE_EN
    tests++; if (best_ms !== 14'd9999) begin fails++; $display("[TB] FAIL reset_best: got %0d, expected 9999", best_ms); end
`endif
    rst = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (number !== 14'd0 || led_go !== 1'b0 || done !== 1'b0 || false_start !== 1'b0) bad = 1'b1;
    end
    tests++; if (bad !== 1'b0) begin fails++; $display("[TB] FAIL idle_stable: got bad=%b, expected 0", bad); end
  endtask

  task automatic test_normal_round();
    int d, cyc; bit ok;
    press_start(d);
    tests++; if (done !== 1'b0 || led_go !== 1'b0) begin fails++; $display("[TB] FAIL round_wait_flags: got done=%b go=%b, expected 0 0", done, led_go); end
    wait_go(1'b0, cyc, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("[TB] FAIL round_go_seen: got %b, expected 1", ok); end
    tests++; if (cyc !== 4 * d) begin fails++; $display("[TB] FAIL round_delay: got %0d cycles, expected %0d", cyc, 4 * d); end
    react_at_ms(37, 1'b0);
    tests++; if (number !== 14'd37) begin fails++; $display("[TB] FAIL round_number: got %0d, expected 37", number); end
    tests++; if (done !== 1'b1 || led_go !== 1'b0 || false_start !== 1'b0) begin
      fails++; $display("[TB] FAIL round_flags: got done=%b go=%b fs=%b, expected 1 0 0", done, led_go, false_start); end
`ifdef REACTION_BEST_SCORE_EN
    tests++; if (best_ms !== 14'd37) begin fails++; $display("[TB] FAIL round_best: got %0d, expected 37", best_ms); end
`endif
  endtask

  task automatic test_false_start();
    int d, cyc; bit ok, bad;
    press_start(d);
    tests++; if (number !== 14'd0 || done !== 1'b0) begin fails++; $display("[TB] FAIL fs_start_clear: got num=%0d done=%b, expected 0 0", number, done); end
    bad = (led_go !== 1'b0);
    step(5);
    bad |= (led_go !== 1'b0);
    btn_react = 1'b1;
    step(3);
    btn_react = 1'b0;
    tests++; if (false_start !== 1'b1 || done !== 1'b1 || number !== 14'd0 || led_go !== 1'b0) begin
      fails++; $display("[TB] FAIL fs_result: got fs=%b done=%b num=%0d go=%b, expected 1 1 0 0", false_start, done, number, led_go); end
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (led_go !== 1'b0 || false_start !== 1'b1) bad = 1'b1;
    end
    tests++; if (bad !== 1'b0) begin fails++; $display("[TB] FAIL fs_no_go: got bad=%b, expected 0", bad); end
    press_start(d);
    tests++; if (false_start !== 1'b0 || done !== 1'b0) begin fails++; $display("[TB] FAIL fs_restart: got fs=%b done=%b, expected 0 0", false_start, done); end
    wait_go(1'b0, cyc, ok);
    tests++; if (cyc !== 4 * d) begin fails++; $display("[TB] FAIL fs_round2_delay: got %0d, expected %0d", cyc, 4 * d); end
    react_at_ms(5, 1'b0);
    tests++; if (number !== 14'd5) begin fails++; $display("[TB] FAIL fs_round2_number: got %0d, expected 5", number); end
  endtask

  task automatic test_timeout();
    int d, cyc; bit ok;
    press_start(d);
    wait_go(1'b1, cyc, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("[TB] FAIL to_go_seen: got %b, expected 1", ok); end
    step(79);
    tests++; if (to_done !== 1'b0 || to_led_go !== 1'b1) begin fails++; $display("[TB] FAIL to_early: got done=%b go=%b, expected 0 1", to_done, to_led_go); end
    step(1);
    tests++; if (to_done !== 1'b1 || to_number !== 14'd20 || to_led_go !== 1'b0 || to_false !== 1'b0) begin
      fails++; $display("[TB] FAIL to_expire: got done=%b num=%0d go=%b fs=%b, expected 1 20 0 0", to_done, to_number, to_led_go, to_false); end
    btn_react = 1'b1;
    step(3);
    btn_react = 1'b0;
    step(3);
    tests++; if (to_number !== 14'd20 || to_done !== 1'b1) begin fails++; $display("[TB] FAIL to_react_ignored: got num=%0d done=%b, expected 20 1", to_number, to_done); end
  endtask

  task automatic test_async_reset();
    int d, cyc; bit ok, bad;
    press_start(d);
    wait_go(1'b0, cyc, ok);
    step(10);
    #2;
    tests++; if (led_go !== 1'b1) begin fails++; $display("[TB] FAIL ar_pre_go: got %b, expected 1", led_go); end
    rst = 1'b0;
    #1;
    tests++; if (led_go !== 1'b0 || number !== 14'd0 || done !== 1'b0 || to_led_go !== 1'b0) begin
      fails++; $display("[TB] FAIL ar_async: got go=%b num=%0d done=%b, expected 0 0 0", led_go, number, done); end
    btn_start = 1'b1;
    step(5);
    btn_start = 1'b0;
    step(2);
    rst = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (led_go !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    tests++; if (bad !== 1'b0) begin fails++; $display("[TB] FAIL ar_no_event: got bad=%b, expected 0", bad); end
  endtask

  task automatic test_held_button();
    int d, cyc; bit ok, bad;
    btn_start = 1'b1;
    step(2);
    d = 5 + int'(lfsr_m[1:0]);
    step(1);
    wait_go(1'b0, cyc, ok);
    tests++; if (cyc !== 4 * d) begin fails++; $display("[TB] FAIL held_delay: got %0d, expected %0d", cyc, 4 * d); end
    react_at_ms(6, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (done !== 1'b1) bad = 1'b1;
    end
    tests++; if (bad !== 1'b0 || number !== 14'd6) begin fails++; $display("[TB] FAIL held_start_once: got bad=%b num=%0d, expected 0 6", bad, number); end
    btn_start = 1'b0;
    press_start(d);
    tests++; if (done !== 1'b0 || false_start !== 1'b0) begin fails++; $display("[TB] FAIL held_react_start: got done=%b fs=%b, expected 0 0", done, false_start); end
    step(10);
    tests++; if (false_start !== 1'b0 || done !== 1'b0) begin fails++; $display("[TB] FAIL held_react_once: got fs=%b done=%b, expected 0 0", false_start, done); end
    btn_react = 1'b0;
    step(3);
  endtask

`ifdef REACTION_BEST_SCORE_EN
  task automatic best_round(input int ms, input int exp_best);
    int d, cyc; bit ok;
    press_start(d);
    wait_go(1'b0, cyc, ok);
    react_at_ms(ms, 1'b0);
    tests++; if (number !== 14'(ms) || best_ms !== 14'(exp_best)) begin
      fails++; $display("[TB] FAIL best_round_%0d: got num=%0d best=%0d, expected %0d %0d", ms, number, best_ms, ms, exp_best); end
  endtask

  task automatic test_best_score();
    int d;
    #2 rst = 1'b0;
    step(2);
    rst = 1'b1;
    tests++; if (best_ms !== 14'd9999) begin fails++; $display("[TB] FAIL best_reset: got %0d, expected 9999", best_ms); end
    best_round(30, 30);
    best_round(12, 12);
    press_start(d);
    step(5);
    btn_react = 1'b1;
    step(3);
    btn_react = 1'b0;
    tests++; if (false_start !== 1'b1 || best_ms !== 14'd12) begin fails++; $display("[TB] FAIL best_false_start: got fs=%b best=%0d, expected 1 12", false_start, best_ms); end
    best_round(25, 12);
  endtask
`endif

  initial begin
    test_reset();
    test_normal_round();
    test_false_start();
    test_timeout();
    test_async_reset();
    test_held_button();
`ifdef REACTION_BEST_SCORE_EN
    test_best_score();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Game-control core of the reaction game; produces the 14-bit `number` consumed by the 7-segment display block.
- Accepts the start and react buttons and waits a pseudo-random delay before asserting the "go" light.
- Measures the reaction time in milliseconds and presents it as 0..9999, with false-start detection.
- Sits between the raw button pins and the display; runs entirely on the main clock, with no derived clocks.

Parameters:
- TICK_DIV, 100000: main-clock cycles per 1 ms tick (100 MHz board); the bench overrides it to a small value.
- MIN_DELAY_MS, 1000: fixed part of the random pre-go delay, in ms.
- RAND_BITS, 11: LFSR bits added to the delay; random part is 0..2^RAND_BITS-1 ms.
- MAX_MS, 9999: saturation and timeout value for the measured time.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  main clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- btn_start  in  1  raw start button, asynchronous to clk.
- btn_react  in  1  raw react button, asynchronous to clk.
- number  out  14  value for the display: reaction time in ms, 0..9999.
- led_go  out  1  "react now" indicator.
- done  out  1  high while a result (valid or false start) is held.
- false_start  out  1  high while the held result is a false start.

Behaviour:
- Reset (rst=0, async): number=0, led_go=0, done=0, false_start=0; state=IDLE; LFSR=LFSR_SEED; all counters 0.
- Input path:
  - Each button passes through a 2-FF synchronizer, then a rising-edge detector (one-cycle pulse).
  - Pin-to-event latency is 3 clk cycles.
  - A held button generates only one event.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clk in all states.
- ms tick: prescaler counts 0..TICK_DIV-1 and pulses for one cycle at wrap. It is cleared on entry to WAIT and to MEASURE, so the first tick arrives exactly TICK_DIV cycles after entry.
- States:
  - IDLE: outputs keep their last values (0 after reset).
    - start_evt -> WAIT; load delay = MIN_DELAY_MS + LFSR[RAND_BITS-1:0]; clear done, false_start, number.
  - WAIT: decrement delay on each tick.
    - react_evt -> RESULT with false_start=1, number=0.
    - delay reaches 0 -> MEASURE; led_go=1 in the same cycle the state register updates.
  - MEASURE: ms_count starts at 0 and increments on each tick.
    - react_evt -> RESULT; number=ms_count (current value, i.e. whole ms elapsed); led_go=0.
    - ms_count reaches MAX_MS without react -> RESULT; number=MAX_MS.
  - RESULT: done=1; number held.
    - start_evt -> WAIT (new round, same actions as from IDLE).
    - react_evt ignored.
- Simultaneous start_evt and react_evt:
  - IDLE/RESULT: start wins.
  - WAIT/MEASURE: react wins; start is ignored in those states.
- Width rule: ms_count is 14 bits, saturating and never wrapping; the delay counter is wide enough for MIN_DELAY_MS + 2^RAND_BITS-1.
- Reset mid-round: immediate return to the reset values above; led_go drops asynchronously.

Optional Feature:
- Macro: REACTION_BEST_SCORE_EN.
- Defined:
  - Adds output best_ms [13:0]; reset value MAX_MS.
  - On each MEASURE->RESULT transition caused by react_evt with ms_count < best_ms, best_ms <= ms_count, same cycle as number.
  - Timeouts and false starts never update it.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Shared package reaction_pkg:
  - state enum (IDLE, WAIT, MEASURE, RESULT);
  - MAX_MS and display width 14;
  - LFSR tap constant.
- One natural sub-module: btn_sync_edge (2-FF synchronizer + rising-edge pulse), instantiated twice.
- LFSR and FSM stay in reaction_timer.

Test Plan:
- Reset/idle: rst=0 then 1, no buttons -> number=0, led_go=0, done=0, false_start=0 for 1000 cycles.
- Normal round: TICK_DIV=4, MIN_DELAY_MS=5, RAND_BITS=2, seed 16'hACE1. Pulse start, wait for led_go, press react after 37 ms of ticks -> number=37, done=1, led_go=0, false_start=0.
- False start: press react during WAIT -> false_start=1, done=1, number=0, led_go never asserted. Then start -> new WAIT, flags cleared.
- Timeout: MAX_MS=20, no react after go -> number=20, done=1 exactly 20 ticks after led_go rose. react_evt in RESULT leaves number=20.
- Async reset mid-MEASURE: drop rst while led_go=1 -> led_go=0 and number=0 without a clk edge; no events while rst=0. Held button: hold start 50 cycles -> exactly one WAIT entry.
- With REACTION_BEST_SCORE_EN: rounds of 30, 12, false start, 25 ms -> best_ms = 9999, 30, 12, 12, 12.
